// File: rtl/gray_updown_counter.sv
// Up/down binary counter with registered Gray-code mirror, wrap/saturate pulses and zero flag.
// Optional in-module assertions are enabled by defining GRAY_UPDOWN_SVA_EN.
module gray_updown_counter #(
  parameter int WIDTH    = 12,
  parameter bit SATURATE = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             dir,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] bin_c,
  output logic [WIDTH-1:0] gray_c,
  output logic             zero,
  output logic             wrap,
  output logic             sat
);

  logic [WIDTH-1:0] bin_nxt;
  logic             wrap_nxt;
  logic             sat_nxt;
  logic             at_max;
  logic             at_min;
  logic             at_lim;

  assign at_max = &bin_c;
  assign at_min = ~|bin_c;
  assign at_lim = (dir & at_max) | (~dir & at_min);

  always_comb begin
    bin_nxt  = bin_c;
    wrap_nxt = 1'b0;
    sat_nxt  = 1'b0;
    if (load) begin
      bin_nxt = load_val;
    end else if (en) begin
      if (at_lim) begin
        if (SATURATE) begin
          sat_nxt = 1'b1;
        end else begin
          bin_nxt  = dir ? '0 : '1;
          wrap_nxt = 1'b1;
        end
      end else begin
        bin_nxt = dir ? bin_c + WIDTH'(1) : bin_c - WIDTH'(1);
      end
    end
  end

  // Gray is derived from the next binary value so both registers update on the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      bin_c  <= '0;
      gray_c <= '0;
      wrap   <= 1'b0;
      sat    <= 1'b0;
    end else begin
      bin_c  <= bin_nxt;
      gray_c <= bin_nxt ^ (bin_nxt >> 1);
      wrap   <= wrap_nxt;
      sat    <= sat_nxt;
    end
  end

  assign zero = at_min & ~rst;

`ifdef GRAY_UPDOWN_SVA_EN
  logic [32:0] live_cnt;

  always_ff @(posedge clk) begin
    if (rst || !en || !dir || load || zero) live_cnt <= '0;
    else                                    live_cnt <= live_cnt + 33'd1;
  end

  a_gray_consistent: assert property (@(posedge clk) gray_c == (bin_c ^ (bin_c >> 1)));

  a_gray_one_bit: assert property (@(posedge clk) disable iff (rst)
    (!load && en && !(SATURATE && at_lim)) |=> $onehot(gray_c ^ $past(gray_c)));

  a_wrap_sat_excl: assert property (@(posedge clk) !(wrap && sat));

  generate
    if (!SATURATE) begin : g_live
      // A held up-count must revisit zero within one full period, then leave it.
      a_live_reach: assert property (@(posedge clk) disable iff (rst)
        live_cnt < (33'd1 << WIDTH));
      a_live_leave: assert property (@(posedge clk) disable iff (rst)
        (zero && en && dir && !load) |=> !zero);
    end
  endgenerate
`endif

endmodule

// File: tb/tb_gray_updown_counter.sv
// Directed bench: WIDTH=4 counter in wrap mode (u_mod) and saturate mode (u_sat) on shared inputs.
module tb_gray_updown_counter;

  logic       clk = 1'b0;
  logic       rst, en, dir, load;
  logic [3:0] load_val;
  logic [3:0] bin_m, gray_m, bin_s, gray_s;
  logic       zero_m, wrap_m, sat_m, zero_s, wrap_s, sat_s;
  int         checks = 0;
  int         errors = 0;
  logic [3:0] gtab [0:15] = '{4'd0, 4'd1, 4'd3, 4'd2, 4'd6, 4'd7, 4'd5, 4'd4,
                              4'd12, 4'd13, 4'd15, 4'd14, 4'd10, 4'd11, 4'd9, 4'd8};

  always #5 clk = ~clk;

  gray_updown_counter #(.WIDTH(4), .SATURATE(1'b0)) u_mod (
    .clk(clk), .rst(rst), .en(en), .dir(dir), .load(load), .load_val(load_val),
    .bin_c(bin_m), .gray_c(gray_m), .zero(zero_m), .wrap(wrap_m), .sat(sat_m));

  gray_updown_counter #(.WIDTH(4), .SATURATE(1'b1)) u_sat (
    .clk(clk), .rst(rst), .en(en), .dir(dir), .load(load), .load_val(load_val),
    .bin_c(bin_s), .gray_c(gray_s), .zero(zero_s), .wrap(wrap_s), .sat(sat_s));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; en = 1'b0; dir = 1'b1; load = 1'b0; load_val = 4'd0;
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b1; dir = 1'b1; load = 1'b1; load_val = 4'd5;
    step();
    checks++; if (bin_m !== 4'd0)  begin errors++; $display("FAIL reset_bin got %0d exp 0", bin_m); end
    checks++; if (gray_m !== 4'd0) begin errors++; $display("FAIL reset_gray got %0d exp 0", gray_m); end
    checks++; if (wrap_m !== 1'b0 || sat_s !== 1'b0) begin errors++; $display("FAIL reset_flags wrap %b sat %b exp 0 0", wrap_m, sat_s); end
    checks++; if (zero_m !== 1'b0) begin errors++; $display("FAIL reset_zero_in_rst got %b exp 0", zero_m); end
    rst = 1'b0; en = 1'b0; load = 1'b0;
    #1;
    checks++; if (zero_m !== 1'b1) begin errors++; $display("FAIL reset_zero_after got %b exp 1", zero_m); end
  endtask

  task automatic test_count_up();
    do_reset();
    en = 1'b1; dir = 1'b1;
    for (int i = 1; i <= 17; i++) begin
      step();
      checks++; if (bin_m !== 4'(i % 16)) begin errors++; $display("FAIL up_bin[%0d] got %0d exp %0d", i, bin_m, i % 16); end
      checks++; if (gray_m !== gtab[i % 16]) begin errors++; $display("FAIL up_gray[%0d] got %b exp %b", i, gray_m, gtab[i % 16]); end
      checks++; if (wrap_m !== (i == 16)) begin errors++; $display("FAIL up_wrap[%0d] got %b exp %b", i, wrap_m, (i == 16)); end
      checks++; if (bin_s !== ((i >= 15) ? 4'd15 : 4'(i))) begin errors++; $display("FAIL up_sat_bin[%0d] got %0d", i, bin_s); end
      checks++; if (sat_s !== (i >= 16) || wrap_s !== 1'b0) begin errors++; $display("FAIL up_sat_flags[%0d] sat %b wrap %b", i, sat_s, wrap_s); end
    end
  endtask

  task automatic test_count_down();
    do_reset();
    en = 1'b1; dir = 1'b0;
    step();
    checks++; if (bin_m !== 4'd15 || wrap_m !== 1'b1) begin errors++; $display("FAIL down_wrap bin %0d wrap %b exp 15 1", bin_m, wrap_m); end
    checks++; if (gray_m !== 4'b1000) begin errors++; $display("FAIL down_gray got %b exp 1000", gray_m); end
    checks++; if (bin_s !== 4'd0 || sat_s !== 1'b1 || zero_s !== 1'b1) begin errors++; $display("FAIL down_sat bin %0d sat %b zero %b exp 0 1 1", bin_s, sat_s, zero_s); end
    step();
    checks++; if (bin_m !== 4'd14 || wrap_m !== 1'b0) begin errors++; $display("FAIL down_next bin %0d wrap %b exp 14 0", bin_m, wrap_m); end
    en = 1'b0;
    step();
    checks++; if (bin_m !== 4'd14 || gray_m !== 4'b1001 || wrap_m !== 1'b0 || sat_s !== 1'b0) begin errors++; $display("FAIL hold bin %0d gray %b wrap %b sat %b exp 14 1001 0 0", bin_m, gray_m, wrap_m, sat_s); end
  endtask

  task automatic test_saturate();
    load = 1'b1; load_val = 4'd14; en = 1'b0;
    step();
    checks++; if (bin_s !== 4'd14 || bin_m !== 4'd14 || sat_s !== 1'b0) begin errors++; $display("FAIL sat_load bin_s %0d bin_m %0d sat %b exp 14 14 0", bin_s, bin_m, sat_s); end
    load = 1'b0; en = 1'b1; dir = 1'b1;
    step();
    checks++; if (bin_s !== 4'd15 || sat_s !== 1'b0 || wrap_s !== 1'b0) begin errors++; $display("FAIL sat_1 bin %0d sat %b wrap %b exp 15 0 0", bin_s, sat_s, wrap_s); end
    step();
    checks++; if (bin_s !== 4'd15 || sat_s !== 1'b1 || wrap_s !== 1'b0) begin errors++; $display("FAIL sat_2 bin %0d sat %b wrap %b exp 15 1 0", bin_s, sat_s, wrap_s); end
    checks++; if (bin_m !== 4'd0 || wrap_m !== 1'b1) begin errors++; $display("FAIL sat_mod_wrap bin %0d wrap %b exp 0 1", bin_m, wrap_m); end
    step();
    checks++; if (bin_s !== 4'd15 || sat_s !== 1'b1 || gray_s !== 4'b1000) begin errors++; $display("FAIL sat_3 bin %0d sat %b gray %b exp 15 1 1000", bin_s, sat_s, gray_s); end
    checks++; if (bin_m !== 4'd1 || wrap_m !== 1'b0) begin errors++; $display("FAIL sat_mod_next bin %0d wrap %b exp 1 0", bin_m, wrap_m); end
  endtask

  task automatic test_load_en();
    load = 1'b1; load_val = 4'd9; en = 1'b1; dir = 1'b1;
    step();
    checks++; if (bin_m !== 4'd9 || gray_m !== 4'b1101 || wrap_m !== 1'b0) begin errors++; $display("FAIL load_en_mod bin %0d gray %b wrap %b exp 9 1101 0", bin_m, gray_m, wrap_m); end
    checks++; if (bin_s !== 4'd9 || gray_s !== 4'b1101 || sat_s !== 1'b0) begin errors++; $display("FAIL load_en_sat bin %0d gray %b sat %b exp 9 1101 0", bin_s, gray_s, sat_s); end
  endtask

  task automatic test_dir_change();
    load = 1'b1; load_val = 4'd5; en = 1'b0;
    step();
    load = 1'b0; en = 1'b1; dir = 1'b1;
    step();
    checks++; if (bin_m !== 4'd6 || gray_m !== 4'b0101) begin errors++; $display("FAIL dir_up bin %0d gray %b exp 6 0101", bin_m, gray_m); end
    dir = 1'b0;
    step();
    checks++; if (bin_m !== 4'd5 || gray_m !== 4'b0111) begin errors++; $display("FAIL dir_down bin %0d gray %b exp 5 0111", bin_m, gray_m); end
    dir = 1'b1;
    step();
    checks++; if (bin_m !== 4'd6 || bin_s !== 4'd6) begin errors++; $display("FAIL dir_up2 bin_m %0d bin_s %0d exp 6 6", bin_m, bin_s); end
  endtask

  task automatic test_mid_reset();
    load = 1'b1; load_val = 4'd7; en = 1'b0;
    step();
    checks++; if (bin_m !== 4'd7) begin errors++; $display("FAIL mid_pre bin %0d exp 7", bin_m); end
    rst = 1'b1; load = 1'b1; load_val = 4'd3; en = 1'b1;
    step();
    checks++; if (bin_m !== 4'd0 || gray_m !== 4'd0 || zero_m !== 1'b0) begin errors++; $display("FAIL mid_rst bin %0d gray %b zero %b exp 0 0000 0", bin_m, gray_m, zero_m); end
    step();
    checks++; if (zero_m !== 1'b0 || zero_s !== 1'b0) begin errors++; $display("FAIL mid_rst_hold zero %b %b exp 0 0", zero_m, zero_s); end
    rst = 1'b0; load = 1'b0; en = 1'b0;
    #1;
    checks++; if (zero_m !== 1'b1) begin errors++; $display("FAIL mid_zero_after got %b exp 1", zero_m); end
    en = 1'b1; dir = 1'b1;
    step();
    checks++; if (bin_m !== 4'd1 || zero_m !== 1'b0) begin errors++; $display("FAIL mid_first_step bin %0d zero %b exp 1 0", bin_m, zero_m); end
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; dir = 1'b1; load = 1'b0; load_val = 4'd0;
    #2;
    test_reset();
    test_count_up();
    test_count_down();
    test_saturate();
    test_load_en();
    test_dir_change();
    test_mid_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
